addsub_seq_ctrl: RTL and testbench
==================================

Name: addsub_seq_ctrl

Overview:
- Sequencer that performs NBYTES-wide add/subtract by time-multiplexing one external 8-bit AdderSubtractor unit, one byte per step, LSB first.
- Carry/borrow between bytes is applied with an extra correction pass through the same unit, because the unit has no carry-in.
- Sits between a valid/ready request source and the shared AdderSubtractor instance. Owns that instance's inputs exclusively.

Parameters:
- NBYTES, 4, number of byte lanes in the operands (width W = 8*NBYTES); minimum 1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_a  input  W  operand A
- req_b  input  W  operand B
- req_sub  input  1  0 = A+B, 1 = A-B
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_result  output  W  sum/difference
- rsp_cout  output  1  add: carry out; sub: 1 = no borrow
- rsp_ovf  output  1  signed two's-complement overflow
- au_A  output  8  to unit A
- au_B  output  8  to unit B
- au_Add_ctrl  output  1  to unit Add_ctrl; 0 = add, 1 = subtract
- au_SUM  input  8  from unit SUM; combinational, sampled same cycle
- au_C_out  input  1  from unit C_out; add: carry, sub: 1 = no borrow

Behaviour:
- Reset: all outputs go to 0 immediately on rst_n low. This includes req_ready, rsp_valid, rsp_result, rsp_cout, rsp_ovf, au_A, au_B and au_Add_ctrl. State goes to IDLE. req_ready rises the first cycle after rst_n deasserts.
- Reset asserted mid-operation aborts the operation. The in-flight request is lost and no response is produced.
- States: IDLE, OP, CORR, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register operands and req_sub; set byte index i=0; set chain flag cf.
  - cf reset value: 0 for add; 1 (no borrow) for sub.
  - Go to OP.
- OP:
  - Drive au_A=a[i], au_B=b[i], au_Add_ctrl=sub.
  - Latch r[i]=au_SUM and c1=au_C_out.
  - Correction is needed when (add && cf==1) or (sub && cf==0).
  - If correction is needed, go to CORR.
  - Otherwise set cf=c1, then advance: if i==NBYTES-1 go to DONE, else i++ and stay in OP.
- CORR:
  - Drive au_A=r[i], au_B=8'h01, au_Add_ctrl=sub.
  - Write r[i]=au_SUM and read c2=au_C_out.
  - New cf: add gives c1|c2; sub gives c1&c2.
  - Advance exactly as in OP.
- DONE:
  - rsp_valid=1; rsp_result=r; rsp_cout=cf.
  - rsp_ovf for add: a[W-1]==b[W-1] && r[W-1]!=a[W-1].
  - rsp_ovf for sub: a[W-1]!=b[W-1] && r[W-1]!=a[W-1].
  - Outputs stay stable while rsp_ready=0.
  - On rsp_ready, go to IDLE; rsp_valid drops next cycle.
- req_ready=0 in OP, CORR and DONE. No request overlap; a new request is accepted earliest the cycle after the DONE handshake.
- Latency from accept to rsp_valid:
  - NBYTES cycles of OP plus one CORR cycle per byte that needs correction; range NBYTES to 2*NBYTES-1.
  - Byte 0 never needs correction (initial cf values).
  - rsp_valid asserts the cycle after the last OP/CORR.
- When idle or in DONE, au_* drive 0.
- NBYTES=1 degenerates to a single OP cycle.
- Arithmetic wraps modulo 2^W. rsp_cout and rsp_ovf report the wrap.

Test Plan:
- Add, NBYTES=4, 0x000000FF+0x00000001:
  - Response: rsp_result=0x00000100, rsp_cout=0, rsp_ovf=0.
  - Timing: 5 OP/CORR cycles (CORR on byte 1 only); rsp_valid on cycle 6 after accept.
- Add 0xFFFFFFFF+0x00000001:
  - Response: rsp_result=0x00000000, rsp_cout=1, rsp_ovf=0.
  - Timing: CORR on bytes 1-3; 7 OP/CORR cycles.
- Sub 0x00000000-0x00000001:
  - Response: rsp_result=0xFFFFFFFF, rsp_cout=0 (borrow), rsp_ovf=0.
  - Check: byte 1 CORR gives c1=1, c2=0, so cf=0.
- Add 0x7FFFFFFF+0x00000001: rsp_result=0x80000000, rsp_ovf=1, rsp_cout=0. Sub 0x80000000-0x00000001: rsp_result=0x7FFFFFFF, rsp_ovf=1, rsp_cout=1.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE.
  - rsp_* stay stable and req_ready=0 throughout; a req_valid held meanwhile is not accepted.
  - After the rsp_ready pulse, state returns to IDLE and the request is accepted the next cycle.
- Reset during an active OP/CORR:
  - All outputs 0 immediately; no rsp_valid ever appears for the aborted request.
  - After release, 0x00000005+0x00000003 gives rsp_result=0x00000008 in 4 OP cycles.

Source files
------------

// File: rtl/addsub_seq_ctrl.sv
// Byte-serial NBYTES-wide add/subtract sequencer driving one shared 8-bit AdderSubtractor.
// Inter-byte carry/borrow is folded in by an extra +1/-1 pass through the same unit.
module addsub_seq_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [8*NBYTES-1:0]   req_a,
   input  logic [8*NBYTES-1:0]   req_b,
   input  logic                  req_sub,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [8*NBYTES-1:0]   rsp_result,
   output logic                  rsp_cout,
   output logic                  rsp_ovf,
   output logic [7:0]            au_A,
   output logic [7:0]            au_B,
   output logic                  au_Add_ctrl,
   input  logic [7:0]            au_SUM,
   input  logic                  au_C_out
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {S_IDLE, S_OP, S_CORR, S_DONE} state_t;

   function automatic logic ovf_f(input logic sub, input logic a_msb,
                                  input logic b_msb, input logic r_msb);
      return ((a_msb ^ b_msb) == sub) && (r_msb != a_msb);
   endfunction

   state_t                   state_q;
   logic [NBYTES-1:0][7:0]   a_q, b_q, r_q;
   logic [IW-1:0]            i_q;
   logic                     sub_q, cf_q, c1_q;
   logic                     req_ready_q, rsp_valid_q, rsp_cout_q, rsp_ovf_q;
   logic [W-1:0]             rsp_result_q;
   logic [7:0]               au_a_q, au_b_q;
   logic                     au_ctrl_q;

   logic [NBYTES-1:0][7:0]   r_d;
   logic [IW-1:0]            i_nxt_d;
   logic                     cf_d, corr_d, adv_d, last_d, accept_d;

   always_comb begin
      r_d         = r_q;
      r_d[i_q]    = au_SUM;
      corr_d      = sub_q ? ~cf_q : cf_q;
      cf_d        = au_C_out;
      // In CORR the chain flag merges the main-pass flag with the correction flag
      if (state_q == S_CORR)
         cf_d = sub_q ? (c1_q & au_C_out) : (c1_q | au_C_out);
      adv_d       = (state_q == S_CORR) || ((state_q == S_OP) && !corr_d);
      last_d      = (i_q == LAST);
      i_nxt_d     = i_q + IW'(1);
      accept_d    = (state_q == S_IDLE) && req_valid && req_ready_q;
   end

   always_ff @(posedge clk) begin
      if (accept_d) begin
         a_q <= req_a;
         b_q <= req_b;
      end
      if ((state_q == S_OP) || (state_q == S_CORR))
         r_q <= r_d;
      if (state_q == S_OP)
         c1_q <= au_C_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         i_q          <= '0;
         sub_q        <= 1'b0;
         cf_q         <= 1'b0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_cout_q   <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         au_a_q       <= '0;
         au_b_q       <= '0;
         au_ctrl_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (accept_d) begin
                  sub_q       <= req_sub;
                  cf_q        <= req_sub;
                  i_q         <= '0;
                  req_ready_q <= 1'b0;
                  au_a_q      <= req_a[7:0];
                  au_b_q      <= req_b[7:0];
                  au_ctrl_q   <= req_sub;
                  state_q     <= S_OP;
               end
            end
            S_OP, S_CORR: begin
               if (!adv_d) begin
                  state_q <= S_CORR;
                  au_a_q  <= au_SUM;
                  au_b_q  <= 8'h01;
               end else begin
                  cf_q <= cf_d;
                  if (last_d) begin
                     state_q      <= S_DONE;
                     au_a_q       <= '0;
                     au_b_q       <= '0;
                     au_ctrl_q    <= 1'b0;
                     rsp_valid_q  <= 1'b1;
                     rsp_result_q <= r_d;
                     rsp_cout_q   <= cf_d;
                     rsp_ovf_q    <= ovf_f(sub_q, a_q[NBYTES-1][7], b_q[NBYTES-1][7],
                                           r_d[NBYTES-1][7]);
                  end else begin
                     state_q <= S_OP;
                     i_q     <= i_nxt_d;
                     au_a_q  <= a_q[i_nxt_d];
                     au_b_q  <= b_q[i_nxt_d];
                  end
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  state_q      <= S_IDLE;
                  rsp_valid_q  <= 1'b0;
                  rsp_result_q <= '0;
                  rsp_cout_q   <= 1'b0;
                  rsp_ovf_q    <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_cout    = rsp_cout_q;
   assign rsp_ovf     = rsp_ovf_q;
   assign au_A        = au_a_q;
   assign au_B        = au_b_q;
   assign au_Add_ctrl = au_ctrl_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl: models the 8-bit AdderSubtractor and scoreboards
// results, flags and accept-to-response latency.
module tb_addsub_seq_ctrl;
   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [W-1:0]  req_a = '0;
   logic [W-1:0]  req_b = '0;
   logic          req_sub = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_result;
   logic          rsp_cout;
   logic          rsp_ovf;
   logic [7:0]    au_A, au_B, au_SUM;
   logic          au_Add_ctrl, au_C_out;
   logic [8:0]    au_t;

   always #5 clk = ~clk;

   addsub_seq_ctrl #(.NBYTES(NB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
      .au_A(au_A), .au_B(au_B), .au_Add_ctrl(au_Add_ctrl),
      .au_SUM(au_SUM), .au_C_out(au_C_out)
   );

   // The shared 8-bit unit: no carry-in, C_out is carry for add and "no borrow" for sub
   always_comb begin
      au_t = au_Add_ctrl ? ({1'b0, au_A} - {1'b0, au_B}) : ({1'b0, au_A} + {1'b0, au_B});
   end
   assign au_SUM   = au_t[7:0];
   assign au_C_out = au_Add_ctrl ? ~au_t[8] : au_t[8];

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      exp_t         e;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[9];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: word arithmetic, plus one extra pass per byte receiving carry/borrow
   function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      longint unsigned m, am, bm;
      int ops;
      logic [W:0] s;
      ops = NB;
      for (int i = 1; i < NB; i++) begin
         m  = (64'd1 << (8 * i)) - 64'd1;
         am = 64'(a) & m;
         bm = 64'(b) & m;
         if (sub ? (am < bm) : (((am + bm) >> (8 * i)) != 64'd0)) ops++;
      end
      if (sub) begin
         e.res  = a - b;
         e.cout = (a >= b);
         e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end else begin
         s      = {1'b0, a} + {1'b0, b};
         e.res  = s[W-1:0];
         e.cout = s[W];
         e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      e.cyc = ops + 1;
      return e;
   endfunction

   // Called at a negedge; returns at the first negedge after the accepting edge
   task automatic send(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input bit push);
      int n;
      req_sub   = sub;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 64'(req_ready), 64'd1);
      end else begin
         @(posedge clk);
         if (push) sb_q.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Latency counter starts at 1 for the negedge right after the accepting edge
   task automatic get_rsp(input string name, input int hold);
      int   cnt;
      exp_t e;
      cnt = 1;
      while (!rsp_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: response with empty scoreboard", name);
         return;
      end
      e = sb_q.pop_front();
      chk({name, ".valid"}, 64'(rsp_valid), 64'd1);
      chk({name, ".res"},   64'(rsp_result), 64'(e.res));
      chk({name, ".cout"},  64'(rsp_cout), 64'(e.cout));
      chk({name, ".ovf"},   64'(rsp_ovf), 64'(e.ovf));
      chk({name, ".cyc"},   64'(cnt), 64'(e.cyc));
      chk({name, ".au_idle"}, 64'({au_A, au_B, au_Add_ctrl}), 64'd0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({name, ".hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({name, ".hold_res"},   64'({rsp_result, rsp_cout, rsp_ovf}),
             64'({e.res, e.cout, e.ovf}));
         chk({name, ".hold_ready"}, 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      logic s;
      logic [W-1:0] a, b;
      bit seen;

      tbl[0] = '{1'b0, 32'h000000FF, 32'h00000001, '{32'h00000100, 1'b0, 1'b0, 6}};
      tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b0, 8}};
      tbl[2] = '{1'b1, 32'h00000000, 32'h00000001, '{32'hFFFFFFFF, 1'b0, 1'b0, 8}};
      tbl[3] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b1, 8}};
      tbl[4] = '{1'b1, 32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b1, 1'b1, 8}};
      tbl[5] = '{1'b0, 32'h00000005, 32'h00000003, '{32'h00000008, 1'b0, 1'b0, 5}};
      tbl[6] = '{1'b0, 32'h12345678, 32'h11111111, '{32'h23456789, 1'b0, 1'b0, 5}};
      tbl[7] = '{1'b1, 32'h00000005, 32'h00000003, '{32'h00000002, 1'b1, 1'b0, 5}};
      tbl[8] = '{1'b0, 32'h80000000, 32'h80000000, '{32'h00000000, 1'b1, 1'b1, 5}};

      #2;
      chk("rst.req_ready", 64'(req_ready), 64'd0);
      chk("rst.rsp", 64'({rsp_valid, rsp_result, rsp_cout, rsp_ovf}), 64'd0);
      chk("rst.au", 64'({au_A, au_B, au_Add_ctrl}), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.ready_rise", 64'(req_ready), 64'd1);

      for (int i = 0; i < 9; i++) begin
         send(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].e, 1'b1);
         get_rsp($sformatf("vec%0d", i), 0);
      end

      for (int i = 0; i < 16; i++) begin
         s = 1'(($urandom_range(0, 1)));
         a = $urandom;
         b = (i % 3 == 0) ? 32'h00000001 : $urandom;
         if (i % 4 == 1) a = 32'hFFFFFF00 | a;
         send(s, a, b, model(s, a, b), 1'b1);
         get_rsp($sformatf("rnd%0d", i), 0);
      end

      // Backpressure: next request held valid while the response is stalled
      send(1'b0, 32'h000000FF, 32'h00000001, '{32'h00000100, 1'b0, 1'b0, 6}, 1'b1);
      req_a     = 32'h00000010;
      req_b     = 32'h00000020;
      req_sub   = 1'b0;
      req_valid = 1'b1;
      get_rsp("bp", 3);
      chk("bp.ready_after", 64'(req_ready), 64'd1);
      chk("bp.valid_after", 64'(rsp_valid), 64'd0);
      sb_q.push_back('{32'h00000030, 1'b0, 1'b0, 5});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      get_rsp("bp_next", 0);

      // Reset mid-operation aborts the request silently
      send(1'b0, 32'hFFFFFFFF, 32'h00000001, '{32'h0, 1'b0, 1'b0, 0}, 1'b0);
      @(negedge clk);
      chk("abort.busy", 64'(req_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort.au", 64'({au_A, au_B, au_Add_ctrl}), 64'd0);
      chk("abort.rsp", 64'({rsp_valid, rsp_result, rsp_cout, rsp_ovf}), 64'd0);
      chk("abort.req_ready", 64'(req_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      chk("abort.no_rsp", 64'(seen), 64'd0);
      send(1'b0, 32'h00000005, 32'h00000003, '{32'h00000008, 1'b0, 1'b0, 5}, 1'b1);
      get_rsp("post_rst", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
